// File: rtl/ula_seq_exec.sv
// ---------------------------------------------------------------------------
// ula_seq_exec
//   Sequential ALU execution unit. Logic, arithmetic, compare and LUI ops
//   finish in one cycle. Every shift runs one bit per cycle.
//   Requests use a start/ready handshake. Results use a
//   result_valid/result_ready handshake, so the datapath can stall while a
//   long shift is in progress.
//
// Ports
//   clk           rising-edge clock
//   reset_n       asynchronous, active-low reset
//   start         request valid (only accepted while ready=1)
//   ready         unit can accept a request (IDLE only)
//   operation     4-bit ALU operation code
//   a             operand A; a[SHAMT_W-1:0] is the amount for SLLV/SRLV/SRAV
//   b             operand B; value shifted by every shift, source for LUI
//   shamt         immediate shift amount for SLL/SRL/SRA
//   result        registered result, held after the handoff
//   result_valid  result, zero and overflow are valid
//   result_ready  consumer accepts the result
//   zero          result == 0, registered with result
//   overflow      signed overflow for ADD/SUB, 0 for every other op
//
// WIDTH must be a power of two, at least 8. SHAMT_W must equal log2(WIDTH).
// ---------------------------------------------------------------------------
module ula_seq_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               ready,
  input  logic [3:0]         operation,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               zero,
  output logic               overflow
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRA  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRAV = 4'b1010;
  localparam logic [3:0] OP_LUI  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_SLLV = 4'b1110;
  localparam logic [3:0] OP_SRLV = 4'b1111;

  localparam int                 MSB     = WIDTH - 1;
  localparam int                 HALF    = WIDTH / 2;
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shkind_t;

  // One-bit shift step used by the iterative shifter.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input shkind_t          k);
    case (k)
      SH_LL:   return {v[MSB-1:0], 1'b0};
      SH_RL:   return {1'b0, v[MSB:1]};
      default: return {v[MSB], v[MSB:1]};
    endcase
  endfunction

  state_t              r_state, w_state_nxt;
  logic [WIDTH-1:0]    r_result, w_result_nxt;
  logic                r_zero, w_zero_nxt;
  logic                r_ovf, w_ovf_nxt;
  logic [WIDTH-1:0]    r_acc, w_acc_nxt;
  logic [SHAMT_W-1:0]  r_cnt, w_cnt_nxt;
  shkind_t             r_kind, w_kind_nxt;

  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  logic [WIDTH-1:0]        w_sum;
  logic [WIDTH-1:0]        w_diff;
  logic [WIDTH-1:0]        w_alu;
  logic                    w_alu_ovf;
  logic                    w_is_shift;
  shkind_t                 w_kind;
  logic [SHAMT_W-1:0]      w_amt;
  logic [WIDTH-1:0]        w_shifted;

  assign w_a_s  = a;
  assign w_b_s  = b;
  assign w_sum  = a + b;
  assign w_diff = a - b;

  // Operation decode on the live inputs; only used on the accepting edge.
  always_comb begin
    w_alu      = a & b;
    w_alu_ovf  = 1'b0;
    w_is_shift = 1'b0;
    w_kind     = SH_LL;
    w_amt      = shamt;
    case (operation)
      OP_AND:  w_alu = a & b;
      OP_OR:   w_alu = a | b;
      OP_ADD: begin
        w_alu     = w_sum;
        w_alu_ovf = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_alu     = w_diff;
        w_alu_ovf = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_NOR:  w_alu = ~(a | b);
      OP_XOR:  w_alu = a ^ b;
      OP_LUI:  w_alu = {b[HALF-1:0], {HALF{1'b0}}};
      OP_SLL: begin
        w_is_shift = 1'b1;
        w_kind     = SH_LL;
      end
      OP_SRL: begin
        w_is_shift = 1'b1;
        w_kind     = SH_RL;
      end
      OP_SRA: begin
        w_is_shift = 1'b1;
        w_kind     = SH_RA;
      end
      OP_SLLV: begin
        w_is_shift = 1'b1;
        w_kind     = SH_LL;
        w_amt      = a[SHAMT_W-1:0];
      end
      OP_SRLV: begin
        w_is_shift = 1'b1;
        w_kind     = SH_RL;
        w_amt      = a[SHAMT_W-1:0];
      end
      OP_SRAV: begin
        w_is_shift = 1'b1;
        w_kind     = SH_RA;
        w_amt      = a[SHAMT_W-1:0];
      end
      // 1001 is unused and executes as AND.
      default: w_alu = a & b;
    endcase
  end

  assign w_shifted = shift_one(r_acc, r_kind);

  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_zero_nxt   = r_zero;
    w_ovf_nxt    = r_ovf;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_kind_nxt   = r_kind;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!w_is_shift) begin
            w_result_nxt = w_alu;
            w_zero_nxt   = (w_alu == '0);
            w_ovf_nxt    = w_alu_ovf;
            w_state_nxt  = S_DONE;
          end else if (w_amt == '0) begin
            w_result_nxt = b;
            w_zero_nxt   = (b == '0);
            w_ovf_nxt    = 1'b0;
            w_state_nxt  = S_DONE;
          end else begin
            w_acc_nxt   = b;
            w_cnt_nxt   = w_amt;
            w_kind_nxt  = w_kind;
            w_state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        w_acc_nxt = w_shifted;
        w_cnt_nxt = r_cnt - CNT_ONE;
        // The last shift step and the move to DONE share one edge.
        if (r_cnt == CNT_ONE) begin
          w_result_nxt = w_shifted;
          w_zero_nxt   = (w_shifted == '0);
          w_ovf_nxt    = 1'b0;
          w_state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control and architecturally visible result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_zero   <= w_zero_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  // Shifter working registers; meaningless outside SHIFT, so no reset.
  always_ff @(posedge clk) begin
    r_acc  <= w_acc_nxt;
    r_cnt  <= w_cnt_nxt;
    r_kind <= w_kind_nxt;
  end

  assign ready        = (r_state == S_IDLE);
  assign result_valid = (r_state == S_DONE);
  assign result       = r_result;
  assign zero         = r_zero;
  assign overflow     = r_ovf;

endmodule

// File: doc/ula_seq_exec.md
Name: ula_seq_exec

Overview:
- Sequential ALU execution unit that consumes the 4-bit ALU operation code produced by the ALU-control decoder and executes it on two operands.
- Logic ops, arithmetic, compares and LUI complete in one cycle. All shifts run iteratively at one bit per cycle.
- Sits between the register-read stage and writeback.
- Uses a start/ready request handshake and a valid/ready result handshake so the datapath can stall on long shifts.

Parameters:
- WIDTH, 32, operand/result width. Must be a power of two, at least 8.
- SHAMT_W, 5, shift-amount width. Must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request valid.
- ready  output  1  unit can accept a request. High only in IDLE.
- operation  input  4  ALU operation code.
- a  input  WIDTH  operand A. For SLLV/SRLV/SRAV, a[SHAMT_W-1:0] is the shift amount.
- b  input  WIDTH  operand B. B is the value shifted by every shift op and the source for LUI.
- shamt  input  SHAMT_W  immediate shift amount for SLL/SRL/SRA.
- result  output  WIDTH  registered result.
- result_valid  output  1  result, zero and overflow are valid.
- result_ready  input  1  consumer accepts the result.
- zero  output  1  result == 0. Registered together with result.
- overflow  output  1  signed overflow for ADD/SUB. 0 for all other ops.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; result=0; result_valid=0; zero=0; overflow=0; ready=1 once reset is released. Reset mid-operation aborts the operation; the result is discarded.
- Operation code decode:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB.
  - 0111 SLT (signed, result 1/0); 1000 SLTU (unsigned, result 1/0).
  - 1100 NOR; 1101 XOR; 1011 LUI = {b[WIDTH/2-1:0], zeros}.
  - 0011 SLL b by shamt; 0101 SRL b by shamt; 0100 SRA b by shamt.
  - 1110 SLLV, 1111 SRLV, 1010 SRAV: shift b by a[SHAMT_W-1:0].
  - 1001 (unused code): executes as AND.
- Add/sub: wraps modulo 2^WIDTH. overflow = operand sign bits agree (ADD) or differ (SUB) and result sign differs from a's sign.
- State machine:
  - IDLE: ready=1. When start & ready, latch operation, a, b and the shift amount.
    - Non-shift op: register result, zero and overflow; go to DONE.
    - Shift op with amount 0: result=b; go to DONE.
    - Shift op with amount > 0: acc=b, cnt=amount; go to SHIFT.
  - SHIFT: each cycle shift acc by one bit and decrement cnt.
    - SLL shifts in 0 at the LSB. SRL shifts in 0 at the MSB. SRA replicates the MSB.
    - On the cycle cnt reaches 0, go to DONE with result=acc.
    - ready=0 throughout. start is ignored.
  - DONE: result_valid=1. result, zero and overflow are held stable until result_ready=1. On result_valid & result_ready, go to IDLE and drop result_valid.
- result holds its last value after the handoff. No new request is accepted in the handoff cycle.
- Latency, counted in clock edges from the accepting edge to the edge at which result_valid=1:
  - Non-shift ops and zero-amount shifts: 1.
  - Shifts by N > 0: N+1 (N shift cycles, then the DONE transition).
  - Maximum latency: WIDTH.
- Inputs are sampled only at the accepting edge. Later changes to a, b, operation or shamt have no effect.
- start while not ready is ignored. It is not queued.

Test Plan:
- ADD a=7, b=5, op=0010 -> result_valid one edge after accept; result=12, zero=0, overflow=0.
- SUB a=0x7FFFFFFF, b=0xFFFFFFFF, op=0110 -> result=0x80000000, overflow=1. Then SUB a=5, b=5 -> result=0, zero=1.
- SRA b=0x80000000, shamt=4, op=0100 -> ready=0 for 4 cycles, result=0xF8000000, valid at accept+5. Also SLLV a=0, b=0x1234 -> result=0x1234 at accept+1.
- SLT vs SLTU with a=0xFFFFFFFF, b=1 -> op 0111 gives result=1; op 1000 gives result=0. LUI b=0x0000ABCD -> result=0xABCD0000.
- Backpressure: hold result_ready=0 for 5 cycles after XOR a=0xF0F0F0F0, b=0xFFFF0000 -> result=0x0F0FF0F0 stays stable with valid=1. Pulsing start during DONE has no effect. Releasing result_ready returns to IDLE next edge.
- Reset mid-shift: SRLV a=31, b=0xFFFFFFFF; drive reset_n low 10 cycles after accept -> result_valid=0, result=0 immediately (asynchronous). After release, ready=1 and a new ADD request completes normally.
